key_match_sequencer: RTL and testbench
======================================

Name: key_match_sequencer

Overview:
- Parametrised, multi-channel key-matching sequencer.
- A shared free-running sequence counter, settable to count up or down and loadable, advances each enabled cycle.
- Each channel presents a request with a key. The channel receives a registered one-cycle ack when its key equals the counter value.
- Per-channel wait tracking flags requests left unmatched for too long. The block is the generalised successor to the single-channel, fixed-width, down-only key matcher.

Parameters:
- WIDTH, 4, width of sequence counter and of each key.
- NUM_CH, 2, number of independent request channels (>=1).
- INIT, all-ones (2^WIDTH-1), counter value after reset.
- TIMEOUT, 16, consecutive unmatched request cycles before timeout asserts (1..2^(WIDTH+2)-1).

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  synchronous reset, active-high.
- cnt_en  in  1  counter advances this cycle when 1.
- cnt_up  in  1  direction: 1 = increment, 0 = decrement.
- load  in  1  load counter from load_val this cycle.
- load_val  in  WIDTH  value loaded when load=1.
- req  in  NUM_CH  per-channel request, bit i = channel i.
- req_key  in  NUM_CH*WIDTH  channel i key in bits [i*WIDTH +: WIDTH].
- ack  out  NUM_CH  per-channel registered match acknowledge.
- timeout  out  NUM_CH  per-channel unmatched-wait flag.
- count  out  WIDTH  current counter value (register output).

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset (rst=1 at an edge):
  - count <= INIT; ack <= 0; all wait counters <= 0, so timeout = 0.
  - Reset overrides every other input. Reset mid-request drops any pending ack and timeout on the next cycle.
- Counter update, priority load > cnt_en:
  - load=1: count <= load_val, whatever cnt_en is.
  - else cnt_en=1: count <= count+1 (cnt_up=1) or count-1 (cnt_up=0), modulo 2^WIDTH.
  - Wrap: 2^WIDTH-1 -> 0 going up; 0 -> 2^WIDTH-1 going down.
  - else: hold.
- Match:
  - match[i] = req[i] && (req_key[i] == count), using the count register value before this edge's update.
  - Channels are independent; any number of channels may match in the same cycle.
- Ack:
  - ack[i] <= match[i]. Latency is exactly 1 cycle. Ack is driven from a flop; there is no combinational path from inputs to ack.
  - ack[i] stays high on consecutive cycles for as long as match[i] holds, e.g. counter disabled with key held equal.
- Wait counter (per channel, WIDTH+2 bits, saturating at TIMEOUT):
  - req[i]=0 or match[i]=1: wait[i] <= 0.
  - else: wait[i] <= min(wait[i]+1, TIMEOUT).
  - timeout[i] = (wait[i] == TIMEOUT), decoded from the registered value. Asserts TIMEOUT cycles after the first unmatched request cycle.
  - Once asserted, timeout stays high until req[i] drops or a match occurs; clears on the cycle after that event.
- Simultaneous events:
  - A load in the same cycle as a match: the match uses the old count; the new value takes effect next cycle.
  - A match on the cycle timeout would assert: wait clears, timeout stays 0, and ack asserts.
- No request handshake beyond req/ack. The requester may hold or drop req freely; ack does not require req to be held afterward.

Test Plan:
1. Reset, WIDTH=4, INIT=15, cnt_en=1, cnt_up=0, req[0]=1, key0=15 on the first post-reset cycle -> ack[0]=1 exactly one cycle later, count=14; ack[0]=0 the following cycle.
2. Wrap: load_val=15 load=1, then cnt_up=1 cnt_en=1 -> count 15,0,1; then cnt_up=0 from 0 -> count 15; key=0 req held -> ack high exactly one cycle after each cycle count==0.
3. Multi-channel: cnt_en=0, load 7; req=2'b11, key0=7, key1=7 -> ack=2'b11 every cycle while held; change key1=3 -> ack=2'b01 one cycle later.
4. Timeout: cnt_en=0, count=15, req[1]=1 key1=3 held -> timeout[1] rises exactly 16 cycles after req first sampled, stays high, and ack[1] stays 0. Load 3 -> ack[1]=1 one cycle after the load takes effect, and timeout[1]=0 that same cycle.
5. Priority/simultaneous: cnt_en=1 and load=1 with load_val=9 while key0 equals the old count -> ack[0]=1 next cycle, and count=9 (not old±1).
6. Reset mid-operation: wait[0]=10 with req held, assert rst one cycle -> ack=0, timeout=0, count=INIT next cycle. With req still held unmatched, timeout reasserts exactly 16 cycles after rst deasserts.

Source files
------------

// File: rtl/key_match_sequencer.sv
// Multi-channel key matcher: a shared up/down loadable sequence counter,
// registered per-channel match acks and saturating per-channel wait timers.
module key_match_sequencer #(
    parameter int               WIDTH   = 4,
    parameter int               NUM_CH  = 2,
    parameter logic [WIDTH-1:0] INIT    = {WIDTH{1'b1}},
    parameter int               TIMEOUT = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cnt_en,
    input  logic                    cnt_up,
    input  logic                    load,
    input  logic [WIDTH-1:0]        load_val,
    input  logic [NUM_CH-1:0]       req,
    input  logic [NUM_CH*WIDTH-1:0] req_key,
    output logic [NUM_CH-1:0]       ack,
    output logic [NUM_CH-1:0]       timeout,
    output logic [WIDTH-1:0]        count
);

    localparam int WW = WIDTH + 2;
    localparam logic [WW-1:0] TO = WW'(TIMEOUT);

    logic [WIDTH-1:0]           count_q, count_d;
    logic [NUM_CH-1:0]          ack_q, ack_d;
    logic [NUM_CH-1:0][WW-1:0]  wait_q, wait_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (cnt_en) begin
            count_d = cnt_up ? count_q + WIDTH'(1) : count_q - WIDTH'(1);
        end
    end

    // Matching uses the pre-update count so a same-cycle load never affects it.
    always_comb begin
        ack_d  = '0;
        wait_d = wait_q;
        for (int i = 0; i < NUM_CH; i++) begin
            ack_d[i] = req[i] && (req_key[i*WIDTH +: WIDTH] == count_q);
            if (!req[i] || ack_d[i]) begin
                wait_d[i] = '0;
            end else if (wait_q[i] != TO) begin
                wait_d[i] = wait_q[i] + WW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= INIT;
            ack_q   <= '0;
            wait_q  <= '0;
        end else begin
            count_q <= count_d;
            ack_q   <= ack_d;
            wait_q  <= wait_d;
        end
    end

    always_comb begin
        timeout = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            timeout[i] = (wait_q[i] == TO);
        end
    end

    assign ack   = ack_q;
    assign count = count_q;

endmodule

// File: tb/tb_key_match_sequencer.sv
// Randomised and directed bench for key_match_sequencer, checked against
// an integer reference model of the counter, acks and wait timers.
module tb_key_match_sequencer;

    localparam int W  = 4;
    localparam int N  = 2;
    localparam int TO = 16;
    localparam int M  = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         cnt_en = 1'b0;
    logic         cnt_up = 1'b0;
    logic         load = 1'b0;
    logic [W-1:0] load_val = '0;
    logic [N-1:0] req = '0;
    logic [N*W-1:0] req_key = '0;
    logic [N-1:0] ack;
    logic [N-1:0] timeout;
    logic [W-1:0] count;

    int pass_cnt = 0;
    int total_cnt = 0;

    int m_count = 0;
    int m_wait [N];
    logic [N-1:0] m_ack = '0;

    key_match_sequencer #(
        .WIDTH(W), .NUM_CH(N), .INIT(4'hF), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst(rst), .cnt_en(cnt_en), .cnt_up(cnt_up),
        .load(load), .load_val(load_val), .req(req), .req_key(req_key),
        .ack(ack), .timeout(timeout), .count(count)
    );

    always #5 clk = ~clk;

    function automatic int key_of(int ch);
        logic [W-1:0] k;
        k = req_key[ch*W +: W];
        return int'(k);
    endfunction

    function automatic logic [N-1:0] m_to();
        logic [N-1:0] t;
        for (int i = 0; i < N; i++) t[i] = (m_wait[i] == TO);
        return t;
    endfunction

    function automatic logic [2*N+W-1:0] m_vec();
        logic [W-1:0] c;
        c = W'(m_count);
        return {m_ack, m_to(), c};
    endfunction

    task automatic model_step();
        if (rst) begin
            m_count = M - 1;
            m_ack = '0;
            for (int i = 0; i < N; i++) m_wait[i] = 0;
        end else begin
            for (int i = 0; i < N; i++) begin
                m_ack[i] = req[i] && (key_of(i) == m_count);
                if (!req[i] || m_ack[i]) m_wait[i] = 0;
                else if (m_wait[i] < TO) m_wait[i] = m_wait[i] + 1;
            end
            if (load) m_count = int'(load_val);
            else if (cnt_en) m_count = (m_count + (cnt_up ? 1 : M - 1)) % M;
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic set_key(int ch, int k);
        req_key[ch*W +: W] = W'(k);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cycle();
        total_cnt++;
        if ({ack, timeout, count} !== 8'h0F) begin
            $display("FAIL reset: got %h expected 0f", {ack, timeout, count});
        end else pass_cnt++;
        rst = 1'b0; cnt_en = 1'b1; cnt_up = 1'b0;
        req = 2'b01; set_key(0, 15);
        cycle();
        total_cnt++;
        if (ack !== 2'b01 || count !== 4'd14) begin
            $display("FAIL first_ack: got ack=%b count=%0d expected ack=01 count=14", ack, count);
        end else pass_cnt++;
        cycle();
        total_cnt++;
        if (ack !== 2'b00 || count !== 4'd13) begin
            $display("FAIL ack_drop: got ack=%b count=%0d expected ack=00 count=13", ack, count);
        end else pass_cnt++;
        req = '0;
    endtask

    task automatic test_wrap();
        int exp_up [4] = '{15, 0, 1, 2};
        load = 1'b1; load_val = 4'd15; cnt_en = 1'b0;
        req = 2'b01; set_key(0, 0);
        for (int c = 0; c < 4; c++) begin
            cycle();
            load = 1'b0; cnt_en = 1'b1; cnt_up = 1'b1;
            total_cnt++;
            if (count !== W'(exp_up[c]) || {ack, timeout, count} !== m_vec()) begin
                $display("FAIL wrap_up c%0d: got %h expected count=%0d vec=%h", c, {ack, timeout, count}, exp_up[c], m_vec());
            end else pass_cnt++;
        end
        total_cnt++;
        if (ack[0] !== 1'b0) begin
            $display("FAIL wrap_up_ack: got %b expected 0", ack[0]);
        end else pass_cnt++;
        load = 1'b1; load_val = 4'd0; cnt_en = 1'b0;
        cycle();
        load = 1'b0; cnt_en = 1'b1; cnt_up = 1'b0;
        cycle();
        total_cnt++;
        if (count !== 4'd15 || ack[0] !== 1'b1) begin
            $display("FAIL wrap_down: got count=%0d ack=%b expected count=15 ack=1", count, ack[0]);
        end else pass_cnt++;
        req = '0; cnt_en = 1'b0;
    endtask

    task automatic test_multi();
        load = 1'b1; load_val = 4'd7; cnt_en = 1'b0;
        cycle();
        load = 1'b0;
        req = 2'b11; set_key(0, 7); set_key(1, 7);
        for (int c = 0; c < 3; c++) begin
            cycle();
            total_cnt++;
            if (ack !== 2'b11) begin
                $display("FAIL multi_both c%0d: got ack=%b expected 11", c, ack);
            end else pass_cnt++;
        end
        set_key(1, 3);
        cycle();
        total_cnt++;
        if (ack !== 2'b01) begin
            $display("FAIL multi_one: got ack=%b expected 01", ack);
        end else pass_cnt++;
        req = '0;
        cycle();
    endtask

    task automatic test_timeout();
        load = 1'b1; load_val = 4'd15; cnt_en = 1'b0;
        cycle();
        load = 1'b0;
        req = 2'b10; set_key(1, 3);
        for (int k = 1; k <= 20; k++) begin
            cycle();
            total_cnt++;
            if (timeout[1] !== (k >= TO) || ack[1] !== 1'b0) begin
                $display("FAIL timeout_rise k%0d: got to=%b ack=%b expected to=%b ack=0", k, timeout[1], ack[1], (k >= TO));
            end else pass_cnt++;
        end
        load = 1'b1; load_val = 4'd3;
        cycle();
        load = 1'b0;
        total_cnt++;
        if (count !== 4'd3 || ack[1] !== 1'b0 || timeout[1] !== 1'b1) begin
            $display("FAIL timeout_load: got count=%0d ack=%b to=%b expected 3 0 1", count, ack[1], timeout[1]);
        end else pass_cnt++;
        cycle();
        total_cnt++;
        if (ack[1] !== 1'b1 || timeout[1] !== 1'b0) begin
            $display("FAIL timeout_clear: got ack=%b to=%b expected ack=1 to=0", ack[1], timeout[1]);
        end else pass_cnt++;
        req = '0;
        cycle();
    endtask

    task automatic test_priority();
        int old;
        old = m_count;
        cnt_en = 1'b1; cnt_up = 1'b1; load = 1'b1; load_val = 4'd9;
        req = 2'b01; set_key(0, old);
        cycle();
        load = 1'b0; cnt_en = 1'b0; req = '0;
        total_cnt++;
        if (ack[0] !== 1'b1 || count !== 4'd9) begin
            $display("FAIL priority: got ack=%b count=%0d expected ack=1 count=9", ack[0], count);
        end else pass_cnt++;
        cycle();
    endtask

    task automatic test_reset_mid();
        load = 1'b1; load_val = 4'd5; cnt_en = 1'b0;
        cycle();
        load = 1'b0;
        req = 2'b01; set_key(0, 3);
        for (int k = 0; k < 10; k++) cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        total_cnt++;
        if ({ack, timeout, count} !== 8'h0F) begin
            $display("FAIL reset_mid: got %h expected 0f", {ack, timeout, count});
        end else pass_cnt++;
        for (int k = 1; k <= 17; k++) begin
            cycle();
            total_cnt++;
            if (timeout[0] !== (k >= TO)) begin
                $display("FAIL reset_retimeout k%0d: got %b expected %b", k, timeout[0], (k >= TO));
            end else pass_cnt++;
        end
        req = '0;
        cycle();
    endtask

    task automatic test_random();
        for (int c = 0; c < 1200; c++) begin
            if (((c / 40) % 2) == 0) begin
                rst    = ($urandom_range(0, 63) == 0);
                load   = ($urandom_range(0, 7) == 0);
                load_val = W'($urandom);
                cnt_en = ($urandom_range(0, 3) != 0);
                cnt_up = 1'($urandom);
                for (int i = 0; i < N; i++) begin
                    req[i] = ($urandom_range(0, 3) != 0);
                    if ($urandom_range(0, 1) == 1) set_key(i, m_count);
                    else set_key(i, $urandom_range(0, M - 1));
                end
            end else begin
                rst = 1'b0; load = 1'b0;
                cnt_en = ($urandom_range(0, 15) == 0);
                if ($urandom_range(0, 31) == 0) req = N'($urandom);
            end
            cycle();
            total_cnt++;
            if ({ack, timeout, count} !== m_vec()) begin
                $display("FAIL random c%0d: got %h expected %h", c, {ack, timeout, count}, m_vec());
            end else pass_cnt++;
        end
    endtask

    initial begin
        for (int i = 0; i < N; i++) m_wait[i] = 0;
        #2;
        test_reset();
        test_wrap();
        test_multi();
        test_timeout();
        test_priority();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
